// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch front end.
package fetch_pkg;

  localparam int INSTR_W     = 32;
  localparam int ADDR_W      = 8;
  localparam int FETCH_BYTES = 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 8'd255;
  // Address of the last full word in memory (252).
  localparam logic [ADDR_W-1:0] LAST_WORD = LAST_ADDR - 8'd3;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } q_entry_t;

  // Saturate a decode take request to 2 and to the number of valid slots.
  function automatic logic [1:0] clamp_take(input logic [1:0] take, input logic [1:0] avail);
    logic [1:0] t;
    t = (take == 2'd3) ? 2'd2 : take;
    return (t > avail) ? avail : t;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: 2-wide push, 2-wide peek, 0/1/2 pop and flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = $clog2(QDEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic [1:0]     pop_n,
  input  logic [1:0]     push_n,
  input  q_entry_t       push0,
  input  q_entry_t       push1,
  output logic [CW-1:0]  count,
  output logic [1:0]     peek_valid,
  output q_entry_t       peek0,
  output q_entry_t       peek1
);

  q_entry_t        mem_q [QDEPTH];
  q_entry_t        mem_d [QDEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  // Next-state: pop from head, then append up to two entries at tail.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_n);
      tail_d  = tail_q + PW'(push_n);
      count_d = count_q - CW'(pop_n) + CW'(push_n);
      if (push_n != 2'd0) begin
        mem_d[tail_q] = push0;
      end else begin
        mem_d[tail_q] = mem_q[tail_q];
      end
      if (push_n == 2'd2) begin
        mem_d[tail_q + PW'(1'b1)] = push1;
      end else begin
        mem_d[tail_q + PW'(1'b1)] = mem_q[tail_q + PW'(1'b1)];
      end
    end
  end

  // Pointer and occupancy registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: slots are only visible while counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head peek; invalid slots read as zero.
  always_comb begin
    peek_valid = {count_q >= CW'(2), count_q != '0};
    peek0      = peek_valid[0] ? mem_q[head_q] : '0;
    peek1      = peek_valid[1] ? mem_q[head_q + PW'(1'b1)] : '0;
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch front end: PC register, halt logic and enqueue decision.
// Optional FETCH_ZERO_STOP_EN treats a fetched all-zero word as end of program.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  fetch_addr,
  input  logic [INSTR_W-1:0] instr1_in,
  input  logic [INSTR_W-1:0] instr2_in,
  output logic [1:0]         dec_valid,
  output logic [INSTR_W-1:0] dec_instr0,
  output logic [INSTR_W-1:0] dec_instr1,
  output logic [ADDR_W-1:0]  dec_pc0,
  output logic [ADDR_W-1:0]  dec_pc1,
  input  logic [1:0]         dec_take,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               fetch_halted
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0]     DEPTH_C  = CW'(QDEPTH);
  localparam logic [ADDR_W-1:0] PAIR_END = LAST_WORD - 8'd4;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic [CW-1:0]     count_s;
  logic [1:0]        avail_s, take_s, push_n_s;
  logic [CW-1:0]     free_s;
  logic              flush_s;
  q_entry_t          push0_s, push1_s, peek0_s, peek1_s;

  // Dequeue first, then size the free space seen by this edge's fetch.
  always_comb begin
    avail_s = (count_s >= CW'(2)) ? 2'd2 : count_s[1:0];
    take_s  = clamp_take(dec_take, avail_s);
    free_s  = DEPTH_C - (count_s - CW'(take_s));
  end

  // Enqueue decision; a pair is pushed whole or not at all except at 252.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    flush_s  = 1'b0;
    push_n_s = 2'd0;
    push0_s  = '{instr: instr1_in, pc: pc_q};
    push1_s  = '{instr: instr2_in, pc: pc_q + 8'd4};
    if (redirect_valid) begin
      flush_s  = 1'b1;
      pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
      halted_d = 1'b0;
    end else if (!halted_q) begin
      if (pc_q != LAST_WORD) begin
        if (free_s >= CW'(2)) begin
`ifdef FETCH_ZERO_STOP_EN
          if (instr1_in == 32'h0000_0000) begin
            halted_d = 1'b1;
          end else if (instr2_in == 32'h0000_0000) begin
            push_n_s = 2'd1;
            pc_d     = pc_q + 8'd4;
            halted_d = 1'b1;
          end else begin
            push_n_s = 2'd2;
            pc_d     = pc_q + ADDR_W'(FETCH_BYTES);
            halted_d = (pc_q == PAIR_END);
          end
`else
          push_n_s = 2'd2;
          pc_d     = pc_q + ADDR_W'(FETCH_BYTES);
          halted_d = (pc_q == PAIR_END);
`endif
        end else begin
          push_n_s = 2'd0;
        end
      end else begin
        if (free_s >= CW'(1)) begin
`ifdef FETCH_ZERO_STOP_EN
          if (instr1_in == 32'h0000_0000) begin
            halted_d = 1'b1;
          end else begin
            push_n_s = 2'd1;
            pc_d     = 8'd0;
            halted_d = 1'b1;
          end
`else
          push_n_s = 2'd1;
          pc_d     = 8'd0;
          halted_d = 1'b1;
`endif
        end else begin
          push_n_s = 2'd0;
        end
      end
    end else begin
      push_n_s = 2'd0;
    end
  end

  // PC and halt registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush_s),
    .pop_n      (take_s),
    .push_n     (push_n_s),
    .push0      (push0_s),
    .push1      (push1_s),
    .count      (count_s),
    .peek_valid (dec_valid),
    .peek0      (peek0_s),
    .peek1      (peek1_s)
  );

  assign fetch_addr   = pc_q;
  assign fetch_halted = halted_q;
  assign dec_instr0   = peek0_s.instr;
  assign dec_pc0      = peek0_s.pc;
  assign dec_instr1   = peek1_s.instr;
  assign dec_pc1      = peek1_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a fixed program image; honours FETCH_ZERO_STOP_EN.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  fetch_addr;
  logic [31:0] instr1_in, instr2_in;
  logic [1:0]  dec_valid;
  logic [31:0] dec_instr0, dec_instr1;
  logic [7:0]  dec_pc0, dec_pc1;
  logic [1:0]  dec_take = 2'd0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic        fetch_halted;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_addr(fetch_addr),
    .instr1_in(instr1_in), .instr2_in(instr2_in),
    .dec_valid(dec_valid), .dec_instr0(dec_instr0), .dec_instr1(dec_instr1),
    .dec_pc0(dec_pc0), .dec_pc1(dec_pc1), .dec_take(dec_take),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_halted(fetch_halted)
  );

  function automatic logic [31:0] word_at(input logic [7:0] a);
    case (a)
      8'd0:    word_at = 32'h0050_0093;
      8'd4:    word_at = 32'hff20_0113;
      8'd40:   word_at = 32'h0020_85b3;
      8'd120:  word_at = 32'h0224_4eb3;
      8'd124:  word_at = 32'h0000_0000;
      default: word_at = 32'hC0DE_0000 | {24'h0, a};
    endcase
  endfunction

  always_comb begin
    instr1_in = word_at(fetch_addr);
    instr2_in = word_at(fetch_addr + 8'd4);
  end

  typedef struct {
    string      name;
    bit         rst;
    logic [1:0] take;
    bit         redir;
    logic [7:0] rpc;
    logic [7:0] efa;
    logic [1:0] ev;
    logic [7:0] ep0;
    logic [7:0] ep1;
    bit         eh;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input bit r, input logic [1:0] t, input bit rd,
                     input logic [7:0] rp, input logic [7:0] fa, input logic [1:0] v,
                     input logic [7:0] p0, input logic [7:0] p1, input bit h);
    vec_t x;
    x = '{name: n, rst: r, take: t, redir: rd, rpc: rp, efa: fa, ev: v, ep0: p0, ep1: p1, eh: h};
    vecs.push_back(x);
  endtask

  task automatic check(input string n, input logic [7:0] fa, input logic [1:0] v,
                       input logic [7:0] p0, input logic [7:0] p1, input bit h);
    logic [31:0] ei0, ei1;
    ei0 = v[0] ? word_at(p0) : 32'h0;
    ei1 = v[1] ? word_at(p1) : 32'h0;
    vectors++;
    if (fetch_addr !== fa || dec_valid !== v || dec_pc0 !== p0 || dec_pc1 !== p1 ||
        dec_instr0 !== ei0 || dec_instr1 !== ei1 || fetch_halted !== h) begin
      miscompares++;
      $display("FAIL %s: got fa=%h v=%b i0=%h pc0=%h i1=%h pc1=%h halt=%b; want fa=%h v=%b i0=%h pc0=%h i1=%h pc1=%h halt=%b",
               n, fetch_addr, dec_valid, dec_instr0, dec_pc0, dec_instr1, dec_pc1, fetch_halted,
               fa, v, ei0, p0, ei1, p1, h);
    end
  endtask

  initial begin
    // Each row: outputs expected in this cycle, then inputs for the coming edge.
    add("A0_reset",   1, 2'd2, 0, 8'd0,   8'd0,   2'b00, 8'd0,   8'd0,   0);
    add("A1",         0, 2'd2, 0, 8'd0,   8'd8,   2'b11, 8'd0,   8'd4,   0);
    add("A2",         0, 2'd2, 0, 8'd0,   8'd16,  2'b11, 8'd8,   8'd12,  0);
    add("A3",         0, 2'd2, 0, 8'd0,   8'd24,  2'b11, 8'd16,  8'd20,  0);
    add("B0_reset",   1, 2'd0, 0, 8'd0,   8'd0,   2'b00, 8'd0,   8'd0,   0);
    add("B1",         0, 2'd0, 0, 8'd0,   8'd8,   2'b11, 8'd0,   8'd4,   0);
    add("B2_full",    0, 2'd0, 0, 8'd0,   8'd16,  2'b11, 8'd0,   8'd4,   0);
    add("B3_hold",    0, 2'd2, 1, 8'h2A,  8'd16,  2'b11, 8'd0,   8'd4,   0);
    add("D1_flush",   0, 2'd2, 0, 8'd0,   8'h28,  2'b00, 8'd0,   8'd0,   0);
    add("D2_target",  0, 2'd1, 0, 8'd0,   8'd48,  2'b11, 8'd40,  8'd44,  0);
    add("D3",         0, 2'd0, 0, 8'd0,   8'd56,  2'b11, 8'd44,  8'd48,  0);
    add("C0_reset",   1, 2'd1, 0, 8'd0,   8'd0,   2'b00, 8'd0,   8'd0,   0);
    add("C1",         0, 2'd1, 0, 8'd0,   8'd8,   2'b11, 8'd0,   8'd4,   0);
    add("C2",         0, 2'd1, 0, 8'd0,   8'd16,  2'b11, 8'd4,   8'd8,   0);
    add("C3",         0, 2'd1, 0, 8'd0,   8'd24,  2'b11, 8'd8,   8'd12,  0);
    add("C4",         0, 2'd1, 0, 8'd0,   8'd24,  2'b11, 8'd12,  8'd16,  0);
    add("C5",         0, 2'd1, 0, 8'd0,   8'd32,  2'b11, 8'd16,  8'd20,  0);
    add("C6_take3",   0, 2'd3, 0, 8'd0,   8'd32,  2'b11, 8'd20,  8'd24,  0);
    add("C7",         0, 2'd0, 0, 8'd0,   8'd40,  2'b11, 8'd28,  8'd32,  0);
    add("C8",         0, 2'd2, 1, 8'd248, 8'd40,  2'b11, 8'd28,  8'd32,  0);
    add("E1_at248",   0, 2'd2, 0, 8'd0,   8'd248, 2'b00, 8'd0,   8'd0,   0);
    add("E2_halt",    0, 2'd2, 0, 8'd0,   8'd0,   2'b11, 8'd248, 8'd252, 1);
    add("E3_nopush",  0, 2'd2, 0, 8'd0,   8'd0,   2'b00, 8'd0,   8'd0,   1);
    add("E4",         0, 2'd2, 1, 8'hFE,  8'd0,   2'b00, 8'd0,   8'd0,   1);
    add("E5_at252",   0, 2'd1, 0, 8'd0,   8'd252, 2'b00, 8'd0,   8'd0,   0);
    add("E6_single",  0, 2'd3, 0, 8'd0,   8'd0,   2'b01, 8'd252, 8'd0,   1);
    add("E7",         0, 2'd0, 1, 8'd120, 8'd0,   2'b00, 8'd0,   8'd0,   1);
    add("Z1_at120",   0, 2'd0, 0, 8'd0,   8'd120, 2'b00, 8'd0,   8'd0,   0);
`ifdef FETCH_ZERO_STOP_EN
    add("Z2_stop",    0, 2'd0, 0, 8'd0,   8'd124, 2'b01, 8'd120, 8'd0,   1);
    add("Z3_stop",    0, 2'd0, 0, 8'd0,   8'd124, 2'b01, 8'd120, 8'd0,   1);
`else
    add("Z2_zero",    0, 2'd0, 0, 8'd0,   8'd128, 2'b11, 8'd120, 8'd124, 0);
    add("Z3_zero",    0, 2'd0, 0, 8'd0,   8'd136, 2'b11, 8'd120, 8'd124, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].rst) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
      end else begin
        #1;
      end
      check(vecs[i].name, vecs[i].efa, vecs[i].ev, vecs[i].ep0, vecs[i].ep1, vecs[i].eh);
      dec_take       = vecs[i].take;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
    end

    // Halt at end of memory, then pulse reset without a clock edge.
    @(negedge clk);
    dec_take       = 2'd2;
    redirect_valid = 1'b1;
    redirect_pc    = 8'd248;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_halted", 8'd0, 2'b11, 8'd248, 8'd252, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", 8'd0, 2'b00, 8'd0, 8'd0, 0);
    @(posedge clk);
    #1;
    check("rst_held", 8'd0, 2'b00, 8'd0, 8'd0, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    dec_take = 2'd2;
    @(negedge clk);
    #1;
    check("post_rst", 8'd8, 2'b11, 8'd0, 8'd4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
